universal_reg: RTL
==================

UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: clr  input  1  synchronous clear.
REQ-005 Port: en  input  1  operation enable; 0 = hold.
REQ-006 Port: mode  input  3  operation select, encoding per REQ-012.
REQ-007 Port: d  input  WIDTH  parallel load data.
REQ-008 Port: sin  input  1  serial input for shift modes.
REQ-009 Port: q  output  WIDTH  registered state.
REQ-010 Port: qb  output  WIDTH  bitwise complement of q.
REQ-011 Port: sout, output, 1 bit, registered bit shifted or rotated out. Port: tc, output, 1 bit, terminal-count flag.

Function
REQ-012 When en=1 and clr=0, q SHALL update on each rising clk edge according to mode:
- 000: hold.
- 001: q<=d.
- 010: shift left, q<={q[WIDTH-2:0],sin}.
- 011: shift right, q<={sin,q[WIDTH-1:1]}.
- 100: rotate left, q<={q[WIDTH-2:0],q[WIDTH-1]}.
- 101: rotate right, q<={q[0],q[WIDTH-1:1]}.
- 110: count up, modulo 2^WIDTH.
- 111: count down, modulo 2^WIDTH.
REQ-013 Latency: every mode SHALL take exactly one cycle, with q valid after the same edge.
REQ-014 Count-up from all-ones SHALL wrap to 0, and count-down from 0 SHALL wrap to all-ones; neither mode has a saturation option.
REQ-015 sout SHALL update only in modes 010-101 when en=1 and clr=0.
- Left shift or left rotate: sout captures the old q[WIDTH-1].
- Right shift or right rotate: sout captures the old q[0].
- All other cases: sout holds.
REQ-016 qb SHALL equal ~q at all times, combinationally, with no extra register stage.
REQ-017 tc SHALL be a combinational output, tc = en & ((mode==110 & q==all-ones) | (mode==111 & q==0)).
REQ-018 tc SHALL be 0 in modes 000-101 regardless of q.
REQ-019 en=0 SHALL hold q and sout in every mode and force tc=0.
REQ-020 Priority order: rst > clr > en/mode.
- clr=1 at an edge sets q=0 and sout=0 regardless of en and mode.
REQ-021 Mode changes SHALL take effect on the very next edge, with no pipeline or settling cycle.
REQ-022 X or Z on unused inputs (d outside mode 001, sin outside modes 010/011) SHALL NOT propagate to q or sout.

Reset
REQ-023 rst=1 SHALL immediately force q=0, qb=all-ones and sout=0, without waiting for clk.
REQ-024 While rst=1, tc SHALL follow REQ-017 on q=0; with en=1 and mode=111 this gives tc=1.
REQ-025 Assertion of rst in the middle of any operation SHALL abort it, and no partial update SHALL occur.
REQ-026 On deassertion, the first rising edge after rst falls SHALL perform a normal operation.

Verification (WIDTH=8)
REQ-027 Async reset: assert rst mid-cycle with q=8'hA5 -> q=8'h00, qb=8'hFF, sout=0 before the next edge.
REQ-028 Load then shift left:
- Stimulus: load 8'h81, then shift left with sin=0.
- Required: q=8'h02, sout=1.
- Continued: a shift right with sin=1 gives q=8'h81, sout=0.
REQ-029 Rotate: 8 rotate-left cycles from 8'h01 -> q returns to 8'h01; sout=1 after the 8th cycle.
REQ-030 Counter wrap:
- Count up from 8'hFE -> tc=1 at q=8'hFF, then q=8'h00 and tc=0.
- Count down from 8'h00 -> q=8'hFF.
REQ-031 Priority:
- clr=1 together with en=1 and mode=001, d=8'h55 -> q=8'h00.
- en=0 in mode 110 -> q holds and tc=0.
REQ-032 Randomised: at least 1000 cycles of random mode, en, clr, d and sin checked against a reference model; qb==~q asserted on every cycle.

Source files
------------

// File: rtl/universal_reg.sv
`default_nettype none
// ============================================================================
//  Module   : universal_reg
//  Purpose  : WIDTH-bit universal register. It supports hold, parallel load,
//             logical shift left/right with serial input, rotate left/right,
//             and modulo-2^WIDTH count up/down. It also provides a
//             registered serial-out bit and a combinational terminal-count
//             flag.
//  Ports    : clk  - clock, all state updates on the rising edge
//             rst  - asynchronous active-high reset (q=0, sout=0)
//             clr  - synchronous clear, overrides en/mode
//             en   - operation enable, 0 holds q and sout
//             mode - operation select (see c_MODE_* below)
//             d    - parallel load data
//             sin  - serial input for the shift modes
//             q    - registered state
//             qb   - combinational complement of q
//             sout - registered bit shifted/rotated out
//             tc   - terminal count (all-ones counting up, zero counting down)
//  Revision : 1.0 - initial release
// ============================================================================
module universal_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout,
  output logic             tc
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_LOAD = 3'b001;
  localparam logic [2:0] c_MODE_SHL  = 3'b010;
  localparam logic [2:0] c_MODE_SHR  = 3'b011;
  localparam logic [2:0] c_MODE_ROL  = 3'b100;
  localparam logic [2:0] c_MODE_ROR  = 3'b101;
  localparam logic [2:0] c_MODE_UP   = 3'b110;
  localparam logic [2:0] c_MODE_DOWN = 3'b111;

  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             sout_q;
  logic             sout_d;

  // Next-state selection. d and sin are only referenced in the modes that
  // consume them, so unknowns on these inputs stay out of the state
  // elsewhere.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (clr) begin
      q_d    = '0;
      sout_d = 1'b0;
    end else if (en) begin
      case (mode)
        c_MODE_HOLD: q_d = q_q;
        c_MODE_LOAD: q_d = d;
        c_MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
        end
        c_MODE_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        c_MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        c_MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        c_MODE_UP:   q_d = q_q + c_ONE;
        c_MODE_DOWN: q_d = q_q - c_ONE;
        default:     q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign sout = sout_q;
  // The flag is a function of the current q, so during reset (q=0) it still
  // reports terminal count when en=1 and the mode is count-down.
  assign tc   = en & (((mode == c_MODE_UP)   && (q_q == c_ONES)) ||
                      ((mode == c_MODE_DOWN) && (q_q == '0)));

endmodule
`default_nettype wire
